// File: rtl/control_sequencer_pkg.sv
// Shared constants and the control-word layout for the SAP-1 micro-sequencer.
package control_sequencer_pkg;

  localparam int OPCODE_WIDTH = 4;
  localparam int NUM_STEPS    = 5;
  localparam int STEP_WIDTH   = 3;

  localparam logic [STEP_WIDTH-1:0] T0 = 3'd0;
  localparam logic [STEP_WIDTH-1:0] T1 = 3'd1;
  localparam logic [STEP_WIDTH-1:0] T2 = 3'd2;
  localparam logic [STEP_WIDTH-1:0] T3 = 3'd3;
  localparam logic [STEP_WIDTH-1:0] T4 = 3'd4;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP = 4'd0;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 4'd1;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'd2;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'd3;
  localparam logic [OPCODE_WIDTH-1:0] OP_STA = 4'd4;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI = 4'd5;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 4'd6;
  localparam logic [OPCODE_WIDTH-1:0] OP_JC  = 4'd7;
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = 4'd8;
  localparam logic [OPCODE_WIDTH-1:0] OP_JO  = 4'd9;
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT = 4'd14;
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 4'd15;

  typedef struct packed {
    logic mar_in;
    logic ram_in;
    logic ram_out;
    logic ir_in;
    logic ir_out;
    logic a_in;
    logic a_out;
    logic b_in;
    logic alu_out;
    logic sub;
    logic latch_flags;
    logic out_in;
    logic pc_en;
    logic pc_out;
    logic jump;
  } ctrl_t;

endpackage

// File: rtl/control_sequencer_step_counter.sv
// Modulo-N T-state counter with enable and synchronous active-high reset.
module control_sequencer_step_counter #(
  parameter int NUM_STEPS = 5,
  parameter int WIDTH     = $clog2(NUM_STEPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(NUM_STEPS - 1);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 micro-sequencer: steps T0..T4 and decodes opcode/flags into datapath strobes.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OPCODE_WIDTH = control_sequencer_pkg::OPCODE_WIDTH,
  parameter int NUM_STEPS    = control_sequencer_pkg::NUM_STEPS
) (
  input  logic                    mclk,
  input  logic                    i_reset,
  input  logic                    mclk_en,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic                    i_zero,
  input  logic                    i_carry,
  input  logic                    i_odd,
  output logic [2:0]              o_step,
  output logic                    o_halt,
  output logic                    o_mar_in,
  output logic                    o_ram_in,
  output logic                    o_ram_out,
  output logic                    o_ir_in,
  output logic                    o_ir_out,
  output logic                    o_a_in,
  output logic                    o_a_out,
  output logic                    o_b_in,
  output logic                    o_alu_out,
  output logic                    o_sub,
  output logic                    o_latch_flags,
  output logic                    o_out_in,
  output logic                    o_pc_en,
  output logic                    o_pc_out,
  output logic                    o_jump
);

  logic [STEP_WIDTH-1:0] step;
  logic                  halt;
  logic                  halt_now;
  logic                  advance;
  ctrl_t                 ctrl;

  // The HLT T2 edge freezes the counter on that same edge, so step stays at 2.
  assign halt_now = mclk_en && !halt && (step == T2) && (i_opcode == OP_HLT);
  assign advance  = mclk_en && !halt && !halt_now;

  control_sequencer_step_counter #(
    .NUM_STEPS (NUM_STEPS),
    .WIDTH     (STEP_WIDTH)
  ) u_step_counter (
    .clk    (mclk),
    .reset  (i_reset),
    .enable (advance),
    .count  (step)
  );

  always_ff @(posedge mclk) begin
    if (i_reset) begin
      halt <= 1'b0;
    end else if (halt_now) begin
      halt <= 1'b1;
    end
  end

  // NOTE: ctrl is cleared first so every path assigns it and no latch is inferred.
  always_comb begin
    ctrl = '0;
    if (!halt) begin
      case (step)
        T0: begin
          ctrl.pc_out = 1'b1;
          ctrl.mar_in = 1'b1;
        end
        T1: begin
          ctrl.ram_out = 1'b1;
          ctrl.ir_in   = 1'b1;
          ctrl.pc_en   = 1'b1;
        end
        T2: begin
          case (i_opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ctrl.ir_out = 1'b1;
              ctrl.mar_in = 1'b1;
            end
            OP_LDI: begin
              ctrl.ir_out = 1'b1;
              ctrl.a_in   = 1'b1;
            end
            OP_JMP: begin
              ctrl.ir_out = 1'b1;
              ctrl.jump   = 1'b1;
            end
            OP_JC: begin
              ctrl.ir_out = i_carry;
              ctrl.jump   = i_carry;
            end
            OP_JZ: begin
              ctrl.ir_out = i_zero;
              ctrl.jump   = i_zero;
            end
            OP_JO: begin
              ctrl.ir_out = i_odd;
              ctrl.jump   = i_odd;
            end
            OP_OUT: begin
              ctrl.a_out  = 1'b1;
              ctrl.out_in = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          case (i_opcode)
            OP_LDA: begin
              ctrl.ram_out = 1'b1;
              ctrl.a_in    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ctrl.ram_out = 1'b1;
              ctrl.b_in    = 1'b1;
            end
            OP_STA: begin
              ctrl.a_out  = 1'b1;
              ctrl.ram_in = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
            ctrl.alu_out     = 1'b1;
            ctrl.a_in        = 1'b1;
            ctrl.latch_flags = 1'b1;
            ctrl.sub         = (i_opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_step        = step;
  assign o_halt        = halt;
  assign o_mar_in      = ctrl.mar_in;
  assign o_ram_in      = ctrl.ram_in;
  assign o_ram_out     = ctrl.ram_out;
  assign o_ir_in       = ctrl.ir_in;
  assign o_ir_out      = ctrl.ir_out;
  assign o_a_in        = ctrl.a_in;
  assign o_a_out       = ctrl.a_out;
  assign o_b_in        = ctrl.b_in;
  assign o_alu_out     = ctrl.alu_out;
  assign o_sub         = ctrl.sub;
  assign o_latch_flags = ctrl.latch_flags;
  assign o_out_in      = ctrl.out_in;
  assign o_pc_en       = ctrl.pc_en;
  assign o_pc_out      = ctrl.pc_out;
  assign o_jump        = ctrl.jump;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus random traffic
// compared against a microcode-table reference model.
module tb_control_sequencer;

  logic       mclk = 1'b0;
  logic       i_reset;
  logic       mclk_en;
  logic [3:0] i_opcode;
  logic       i_zero, i_carry, i_odd;
  logic [2:0] o_step;
  logic       o_halt;
  logic       o_mar_in, o_ram_in, o_ram_out, o_ir_in, o_ir_out, o_a_in, o_a_out, o_b_in;
  logic       o_alu_out, o_sub, o_latch_flags, o_out_in, o_pc_en, o_pc_out, o_jump;

  always #5 mclk = ~mclk;

  control_sequencer dut (
    .mclk          (mclk),
    .i_reset       (i_reset),
    .mclk_en       (mclk_en),
    .i_opcode      (i_opcode),
    .i_zero        (i_zero),
    .i_carry       (i_carry),
    .i_odd         (i_odd),
    .o_step        (o_step),
    .o_halt        (o_halt),
    .o_mar_in      (o_mar_in),
    .o_ram_in      (o_ram_in),
    .o_ram_out     (o_ram_out),
    .o_ir_in       (o_ir_in),
    .o_ir_out      (o_ir_out),
    .o_a_in        (o_a_in),
    .o_a_out       (o_a_out),
    .o_b_in        (o_b_in),
    .o_alu_out     (o_alu_out),
    .o_sub         (o_sub),
    .o_latch_flags (o_latch_flags),
    .o_out_in      (o_out_in),
    .o_pc_en       (o_pc_en),
    .o_pc_out      (o_pc_out),
    .o_jump        (o_jump)
  );

  // Strobe mask bit positions.
  localparam int MI = 0,  RI = 1,  RO = 2,  II = 3,  IO = 4,  AI = 5,  AO = 6,  BI = 7;
  localparam int EO = 8,  SU = 9,  FI = 10, OI = 11, CE = 12, CO = 13, JP = 14;

  logic [14:0] ucode [16][5];
  int          exp_step;
  bit          exp_halt;
  int          vectors     = 0;
  int          miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] observed_mask();
    return {o_jump, o_pc_out, o_pc_en, o_out_in, o_latch_flags, o_sub, o_alu_out,
            o_b_in, o_a_out, o_a_in, o_ir_out, o_ir_in, o_ram_out, o_ram_in, o_mar_in};
  endfunction

  function automatic logic [14:0] expected_mask(input int op, input bit z, input bit c, input bit od);
    logic [14:0] m;
    bit          taken;
    if (exp_halt) return '0;
    m = ucode[op][exp_step];
    if (exp_step == 2 && op >= 7 && op <= 9) begin
      taken = (op == 7) ? c : (op == 8) ? z : od;
      if (!taken) m = '0;
    end
    return m;
  endfunction

  task automatic build_ucode();
    for (int op = 0; op < 16; op++) begin
      for (int t = 0; t < 5; t++) ucode[op][t] = '0;
      ucode[op][0] = (15'd1 << CO) | (15'd1 << MI);
      ucode[op][1] = (15'd1 << RO) | (15'd1 << II) | (15'd1 << CE);
    end
    ucode[1][2] = (15'd1 << IO) | (15'd1 << MI);
    ucode[1][3] = (15'd1 << RO) | (15'd1 << AI);
    for (int op = 2; op <= 3; op++) begin
      ucode[op][2] = (15'd1 << IO) | (15'd1 << MI);
      ucode[op][3] = (15'd1 << RO) | (15'd1 << BI);
      ucode[op][4] = (15'd1 << EO) | (15'd1 << AI) | (15'd1 << FI);
    end
    ucode[3][4] |= (15'd1 << SU);
    ucode[4][2] = (15'd1 << IO) | (15'd1 << MI);
    ucode[4][3] = (15'd1 << AO) | (15'd1 << RI);
    ucode[5][2] = (15'd1 << IO) | (15'd1 << AI);
    for (int op = 6; op <= 9; op++) ucode[op][2] = (15'd1 << IO) | (15'd1 << JP);
    ucode[14][2] = (15'd1 << AO) | (15'd1 << OI);
  endtask

  // One clock: drive inputs at the falling edge, compare the decode, then let the edge act.
  task automatic cycle(input int op, input bit z, input bit c, input bit od,
                       input bit en, input bit rst);
    logic [4:0] bus;
    @(negedge mclk);
    i_opcode = 4'(op);
    i_zero   = z;
    i_carry  = c;
    i_odd    = od;
    mclk_en  = en;
    i_reset  = rst;
    #1;
    bus = {o_ram_out, o_ir_out, o_a_out, o_alu_out, o_pc_out};
    check("step", 32'(o_step), 32'(exp_step));
    check("halt", 32'(o_halt), 32'(exp_halt));
    check("strobes", 32'(observed_mask()), 32'(expected_mask(op, z, c, od)));
    check("bus_onehot", 32'($countones(bus) <= 1), 32'd1);
    @(posedge mclk);
    if (rst) begin
      exp_step = 0;
      exp_halt = 1'b0;
    end else if (en && !exp_halt) begin
      if (exp_step == 2 && op == 15) exp_halt = 1'b1;
      else                           exp_step = (exp_step + 1) % 5;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bit z, c, od, en, rst;
    build_ucode();
    i_reset  = 1'b1;
    mclk_en  = 1'b0;
    i_opcode = '0;
    i_zero   = 1'b0;
    i_carry  = 1'b0;
    i_odd    = 1'b0;
    repeat (2) @(posedge mclk);
    exp_step = 0;
    exp_halt = 1'b0;

    // NOP fetch pattern over two instructions.
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 0);

    // SUB then ADD with flags clear.
    for (int i = 0; i < 5; i++) cycle(3, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(2, 0, 0, 0, 1, 0);

    // Conditional jumps: own flag low (others high) then own flag high (others low).
    for (int op = 7; op <= 9; op++) begin
      for (int i = 0; i < 5; i++) cycle(op, op != 8, op != 7, op != 9, 1, 0);
      for (int i = 0; i < 5; i++) cycle(op, op == 8, op == 7, op == 9, 1, 0);
    end

    // Remaining opcodes, one instruction each.
    for (int op = 0; op < 15; op++)
      for (int i = 0; i < 5; i++) cycle(op, 1, 1, 1, 1, 0);

    // HLT freezes at T2 until reset.
    for (int i = 0; i < 3; i++) cycle(15, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++)
      cycle($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), 1, 0);
    cycle(15, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 0);

    // Alternating enable.
    for (int i = 0; i < 10; i++) cycle(5, 0, 0, 0, i % 2 == 0, 0);

    // Reset beats a low enable at T3.
    while (exp_step != 3) cycle(4, 0, 0, 0, 1, 0);
    cycle(4, 0, 0, 0, 0, 1);
    cycle(4, 0, 0, 0, 0, 0);

    // Random traffic; reset comes sooner once halted.
    for (int i = 0; i < 1300; i++) begin
      z   = 1'($urandom_range(0, 1));
      c   = 1'($urandom_range(0, 1));
      od  = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 3) != 0);
      rst = exp_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
      cycle($urandom_range(0, 15), z, c, od, en, rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Micro-sequencer for the SAP-1 datapath.
- Steps a 5-state T-counter on each enabled master-clock tick and decodes the opcode held in the instruction register. Drives every datapath control strobe, including the ALU's flag-latch and subtract controls.
- Consumes the ALU's registered zero/carry/odd flags to resolve conditional jumps.
- Sits between the instruction register / flag outputs and every register, RAM, PC and ALU control input.

Parameters:
- OPCODE_WIDTH, 4, width of the opcode field taken from the IR upper nibble.
- NUM_STEPS, 5, T-states per instruction (T0..T4).

Ports:
- mclk  input  1  master clock; all state changes on its rising edge.
- i_reset  input  1  synchronous, active-high reset, sampled on the rising edge of mclk.
- mclk_en  input  1  clock enable; state advances only when high.
- i_opcode  input  OPCODE_WIDTH  current instruction opcode.
- i_zero, i_carry, i_odd  input  1 each  registered ALU flags.
- o_step  output  3  current T-state, 0..4.
- o_halt  output  1  HLT has executed; machine frozen.
- o_mar_in  output  1  load memory address register (MI).
- o_ram_in  output  1  write RAM (RI).
- o_ram_out  output  1  RAM drives bus (RO).
- o_ir_in  output  1  load instruction register (II).
- o_ir_out  output  1  IR operand nibble drives bus (IO).
- o_a_in  output  1  load A register (AI).
- o_a_out  output  1  A drives bus (AO).
- o_b_in  output  1  load B register (BI).
- o_alu_out  output  1  ALU result drives bus (EO).
- o_sub  output  1  ALU subtract select.
- o_latch_flags  output  1  ALU flag latch (FI).
- o_out_in  output  1  load output register (OI).
- o_pc_en  output  1  PC increment (CE).
- o_pc_out  output  1  PC drives bus (CO).
- o_jump  output  1  load PC from bus (J).

Behaviour:
- State elements: 3-bit step counter and halt flag. Reset values are step=0 and halt=0.
- i_reset has priority over mclk_en. Reset during any step returns to T0 on the next edge and clears halt.
- Step advance:
  - Advances only when mclk_en=1 and halt=0.
  - Sequence is 0→1→2→3→4→0.
  - No early termination; every instruction takes 5 steps.
- Halt:
  - Halt sets on an edge where mclk_en=1, step=2 and opcode=HLT.
  - Step stays at 2 while halted.
  - While halt=1, all strobes are 0 and o_halt=1.
  - Only i_reset clears halt.
- Decode is combinational from step, i_opcode and the flags. Strobes are level signals valid for the whole step. With halt=0, every strobe not listed for the current step is 0.
- Fetch (all opcodes):
  - T0: pc_out, mar_in.
  - T1: ram_out, ir_in, pc_en.
- Opcodes, with T2/T3/T4 strobes:
  - 0 NOP: none.
  - 1 LDA: T2 ir_out, mar_in; T3 ram_out, a_in.
  - 2 ADD: T2 ir_out, mar_in; T3 ram_out, b_in; T4 alu_out, a_in, latch_flags.
  - 3 SUB: as ADD, plus sub at T4.
  - 4 STA: T2 ir_out, mar_in; T3 a_out, ram_in.
  - 5 LDI: T2 ir_out, a_in.
  - 6 JMP: T2 ir_out, jump.
  - 7 JC: T2 ir_out, jump only if i_carry=1; otherwise nothing.
  - 8 JZ: same, gated by i_zero.
  - 9 JO: same, gated by i_odd.
  - 14 OUT: T2 a_out, out_in.
  - 15 HLT: T2 halt sets (see above).
  - 10–13: treated as NOP.
- Flags are sampled combinationally at T2. They are stable because the ALU updates them only at an ADD/SUB T4 edge.
- o_sub is 0 outside SUB T4, so the ALU output is an addition by default.
- With mclk_en=0, outputs hold their current decode; no register changes.
- Invariant: at most one bus driver (ram_out, ir_out, a_out, alu_out, pc_out) is high in any step.

Decomposition:
- Shared package/header holds:
  - opcode constants (NOP..HLT);
  - step constants T0..T4;
  - NUM_STEPS.
- Optional sub-module step_counter: mod-N counter with enable, hold and sync reset.
- Decode stays inline as a case on {step, opcode}.

Test Plan:
- Reset then mclk_en=1 for 10 edges with opcode=0 → step cycles 0,1,2,3,4,0,…; at T0 only pc_out and mar_in are high; at T1 only ram_out, ir_in and pc_en; nothing else.
- opcode=3, flags 0 → T4 shows alu_out=a_in=latch_flags=sub=1; T3 shows ram_out and b_in; opcode=2 gives the same T4 with sub=0.
- opcode=7: i_carry=0 → jump=0 at T2; i_carry=1 → jump=1 and ir_out=1 at T2. Repeat for JZ with i_zero and JO with i_odd.
- opcode=15 → after the T2 edge, o_halt=1, step frozen at 2 and all strobes 0 for 20 enabled edges. Assert i_reset → step=0, halt=0 next edge.
- mclk_en toggled 1/0 alternately → step advances only on enabled edges. i_reset asserted with mclk_en=0 at step 3 → step=0 next edge.
- Random opcodes 0..15 over 1000 enabled cycles → bus-driver one-hot-or-zero invariant holds every cycle.
